// File: rtl/stream_packer_pkg.sv
// Shared helpers for the stream packer: derived field widths used by the top and its timer.
package stream_packer_pkg;

   function automatic int unsigned cnt_width(input int unsigned ratio);
      return $clog2(ratio + 1);
   endfunction

   // The idle timer counts 0..TIMEOUT-1; it needs at least one bit even when disabled.
   function automatic int unsigned timer_width(input int unsigned timeout);
      return (timeout > 1) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/stream_packer_timer.sv
// Idle counter for the packer: counts while enabled, clears on demand, saturates at expiry.
module stream_packer_timer
   import stream_packer_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic clr_i,
   output logic expired_o
);

   localparam int unsigned TW = timer_width(TIMEOUT);
   localparam logic [TW-1:0] LastCount = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit Enabled = (TIMEOUT > 0);

   logic [TW-1:0] timer_q, timer_d;

   assign expired_o = Enabled && (timer_q == LastCount);

   always_comb begin
      timer_d = timer_q;
      if (clr_i) begin
         timer_d = '0;
      end else if (Enabled && en_i && !expired_o) begin
         timer_d = timer_q + TW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

endmodule

// File: rtl/stream_packer.sv
// Packs IN_WIDTH beats into RATIO-lane words ahead of a CDC FIFO; words close on a full
// accumulator, on in_last_i, or when a partial word has sat idle for TIMEOUT cycles.
module stream_packer
   import stream_packer_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = 8,
   parameter int unsigned RATIO     = 4,
   parameter int unsigned TIMEOUT   = 16,
   parameter int unsigned OUT_WIDTH = IN_WIDTH * RATIO,
   parameter int unsigned CNT_WIDTH = cnt_width(RATIO)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IN_WIDTH-1:0]  in_data_i,
   input  logic                 in_valid_i,
   input  logic                 in_last_i,
   output logic                 in_ready_o,
   output logic [OUT_WIDTH-1:0] out_data_o,
   output logic [CNT_WIDTH-1:0] out_cnt_o,
   output logic                 out_last_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i
);

   localparam logic [CNT_WIDTH-1:0] LastLane = CNT_WIDTH'(RATIO - 1);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [OUT_WIDTH-1:0] acc_q, acc_d, acc_merged;
   logic [RATIO-1:0]     lane_we;

   logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
   logic                 out_last_q, out_last_d;
   logic                 out_valid_q, out_valid_d;

   logic out_free, accept, close_word, flush;
   logic timer_en, timer_clr, timer_expired;

   assign out_free   = ~out_valid_q | out_ready_i;
   assign in_ready_o = ~rst_i & out_free;
   assign accept     = in_valid_i & in_ready_o;
   assign close_word = accept & ((cnt_q == LastLane) | in_last_i);
   // An accepted beat always beats a pending timeout.
   assign flush      = ~accept & (cnt_q != '0) & timer_expired & out_free;
   assign timer_en   = (cnt_q != '0) & ~accept;
   assign timer_clr  = accept | flush;

   for (genvar k = 0; k < RATIO; k++) begin : g_lane
      assign lane_we[k] = accept & (cnt_q == CNT_WIDTH'(k));
      assign acc_merged[k*IN_WIDTH +: IN_WIDTH] =
         lane_we[k] ? in_data_i : acc_q[k*IN_WIDTH +: IN_WIDTH];
   end

   always_comb begin
      cnt_d       = cnt_q;
      acc_d       = acc_merged;
      out_data_d  = out_data_q;
      out_cnt_d   = out_cnt_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;

      if (close_word || flush) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (accept) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end

      if (close_word) begin
         out_data_d  = acc_merged;
         out_cnt_d   = cnt_q + CNT_WIDTH'(1);
         out_last_d  = in_last_i;
         out_valid_d = 1'b1;
      end else if (flush) begin
         out_data_d  = acc_q;
         out_cnt_d   = cnt_q;
         out_last_d  = 1'b0;
         out_valid_d = 1'b1;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_cnt_q   <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_cnt_q   <= out_cnt_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   stream_packer_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (timer_en),
      .clr_i    (timer_clr),
      .expired_o(timer_expired)
   );

   assign out_data_o  = out_data_q;
   assign out_cnt_o   = out_cnt_q;
   assign out_last_o  = out_last_q;
   assign out_valid_o = out_valid_q;

endmodule
